// File: rtl/cflog_wr_arbiter.sv
// cflog_wr_arbiter: serialises ACFA appends and Spec-CFA overwrites onto the cflog RAM write port
module cflog_wr_arbiter #(
   parameter int LOG_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              mclk,
   input  logic              puc_rst_n,
   input  logic              cfa_req,
   input  logic [15:0]       cfa_src,
   input  logic [15:0]       cfa_dest,
   output logic              cfa_ack,
   output logic              cfa_drop,
   input  logic              spec_req,
   input  logic [ADDR_W-1:0] spec_addr,
   input  logic [15:0]       spec_upper,
   input  logic [15:0]       spec_lower,
   output logic              spec_ack,
   output logic              spec_err,
   input  logic              clear_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [ADDR_W:0]   log_ptr,
   output logic              log_full,
   output logic [15:0]       drop_cnt
);
   typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, RESP_ERR} state_t;
   localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'(LOG_WORDS - 2);
   state_t            state_q, state_d;
   logic              spec_q, spec_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       hi_q, hi_d, lo_q, lo_d, drop_cnt_q, drop_cnt_d;
   logic [ADDR_W:0]   log_ptr_q, log_ptr_d;
   logic              spec_legal;
   assign log_full   = log_ptr_q > FULL_TH;
   assign spec_legal = ~spec_addr[0] && ({1'b0, spec_addr} + (ADDR_W+1)'(2)) <= log_ptr_q;
   assign log_ptr    = log_ptr_q;
   assign drop_cnt   = drop_cnt_q;
   assign mem_we     = state_q == WR_HI || state_q == WR_LO;
   assign mem_addr   = state_q == WR_HI ? addr_q : state_q == WR_LO ? addr_q + ADDR_W'(1) : '0;
   assign mem_wdata  = state_q == WR_HI ? hi_q : state_q == WR_LO ? lo_q : '0;
   assign cfa_ack    = ~spec_q && (state_q == WR_LO || state_q == RESP_ERR);
   assign cfa_drop   = ~spec_q && state_q == RESP_ERR;
   assign spec_ack   = spec_q && (state_q == WR_LO || state_q == RESP_ERR);
   assign spec_err   = spec_q && state_q == RESP_ERR;
   // next-state: arbitrate in IDLE (clear > spec > cfa), then write the pair or respond with an error
   always_comb begin
      state_d    = state_q;
      spec_d     = spec_q;
      addr_d     = addr_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      log_ptr_d  = log_ptr_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               log_ptr_d  = '0;
               drop_cnt_d = '0;
            end else if (spec_req) begin
               spec_d  = 1'b1;
               addr_d  = spec_addr;
               hi_d    = spec_upper;
               lo_d    = spec_lower;
               state_d = spec_legal ? WR_HI : RESP_ERR;
            end else if (cfa_req) begin
               spec_d  = 1'b0;
               addr_d  = log_ptr_q[ADDR_W-1:0];
               hi_d    = cfa_src;
               lo_d    = cfa_dest;
               state_d = log_full ? RESP_ERR : WR_HI;
            end
         end
         WR_HI: state_d = WR_LO;
         WR_LO: begin
            state_d   = IDLE;
            log_ptr_d = spec_q ? log_ptr_q : log_ptr_q + (ADDR_W+1)'(2);
         end
         RESP_ERR: begin
            state_d    = IDLE;
            drop_cnt_d = (spec_q || drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and latched request registers; async reset aborts any pair in flight
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state_q    <= IDLE;
         spec_q     <= 1'b0;
         addr_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         log_ptr_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         spec_q     <= spec_d;
         addr_q     <= addr_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         log_ptr_q  <= log_ptr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
endmodule

// File: tb/tb_cflog_wr_arbiter.sv
// tb_cflog_wr_arbiter: scoreboard bench for the cflog write arbiter on a small 8-word log
module tb_cflog_wr_arbiter;
   localparam int AW = 8;
   localparam int LW = 8;
   logic          mclk = 1'b0;
   logic          puc_rst_n = 1'b0;
   logic          cfa_req = 1'b0, spec_req = 1'b0, clear_req = 1'b0;
   logic [15:0]   cfa_src = '0, cfa_dest = '0, spec_upper = '0, spec_lower = '0;
   logic [AW-1:0] spec_addr = '0;
   logic          cfa_ack, cfa_drop, spec_ack, spec_err, mem_we, log_full;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata, drop_cnt;
   logic [AW:0]   log_ptr;
   int            n_chk = 0, n_pass = 0, cyc = 0, lat, ts, tc;
   logic [31:0]   wr_q[$];
   logic [3:0]    ack_q[$];
   logic [AW:0]   ptr_m = '0;
   logic [15:0]   drop_m = '0;

   cflog_wr_arbiter #(.LOG_WORDS(LW), .ADDR_W(AW)) dut (
      .mclk(mclk), .puc_rst_n(puc_rst_n),
      .cfa_req(cfa_req), .cfa_src(cfa_src), .cfa_dest(cfa_dest), .cfa_ack(cfa_ack), .cfa_drop(cfa_drop),
      .spec_req(spec_req), .spec_addr(spec_addr), .spec_upper(spec_upper), .spec_lower(spec_lower),
      .spec_ack(spec_ack), .spec_err(spec_err), .clear_req(clear_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .log_ptr(log_ptr), .log_full(log_full), .drop_cnt(drop_cnt)
   );

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // every RAM write and every ack must match the next expected entry, in order
   always @(negedge mclk) if (puc_rst_n) begin
      if (mem_we) check("mem_wr", {8'h0, mem_addr, mem_wdata}, wr_q.size() != 0 ? wr_q.pop_front() : 32'hDEAD0000);
      if (cfa_ack | cfa_drop | spec_ack | spec_err)
         check("ack", {28'h0, cfa_ack, cfa_drop, spec_ack, spec_err}, ack_q.size() != 0 ? {28'h0, ack_q.pop_front()} : 32'hDEAD0000);
   end

   task automatic push_pair(input logic [AW-1:0] a, input logic [15:0] h, input logic [15:0] l);
      wr_q.push_back({8'h0, a, h});
      wr_q.push_back({8'h0, a + AW'(1), l});
   endtask

   task automatic cfa(input logic [15:0] s, input logic [15:0] d, output int l);
      if (ptr_m > 9'(LW - 2)) begin
         ack_q.push_back(4'b1100);
         if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
      end else begin
         push_pair(ptr_m[AW-1:0], s, d);
         ack_q.push_back(4'b1000);
         ptr_m = ptr_m + 9'd2;
      end
      @(posedge mclk); #1;
      cfa_req = 1'b1; cfa_src = s; cfa_dest = d;
      l = 0;
      do begin @(negedge mclk); l++; end while (!cfa_ack && l < 20);
      cfa_req = 1'b0;
      check("cfa_ack_seen", {31'h0, cfa_ack}, 32'h1);
   endtask

   task automatic spec(input logic [AW-1:0] a, input logic [15:0] u, input logic [15:0] lo, output int l);
      if (!a[0] && ({1'b0, a} + 9'd2) <= ptr_m) begin
         push_pair(a, u, lo);
         ack_q.push_back(4'b0010);
      end else ack_q.push_back(4'b0011);
      @(posedge mclk); #1;
      spec_req = 1'b1; spec_addr = a; spec_upper = u; spec_lower = lo;
      l = 0;
      do begin @(negedge mclk); l++; end while (!spec_ack && l < 20);
      spec_req = 1'b0;
      check("spec_ack_seen", {31'h0, spec_ack}, 32'h1);
   endtask

   task automatic status(input string tag);
      @(posedge mclk); #1;
      check({tag, "_ptr"}, 32'(log_ptr), 32'(ptr_m));
      check({tag, "_full"}, 32'(log_full), 32'(ptr_m > 9'(LW - 2)));
      check({tag, "_drop"}, 32'(drop_cnt), 32'(drop_m));
   endtask

   initial begin
      #2;
      check("rst_we", 32'(mem_we), 0);
      check("rst_ptr", 32'(log_ptr), 0);
      check("rst_ack", 32'({cfa_ack, cfa_drop, spec_ack, spec_err}), 0);
      repeat (2) @(posedge mclk); #1 puc_rst_n = 1'b1;
      status("reset");
      cfa(16'hE010, 16'hE200, lat); check("t1_lat", 32'(lat), 3); status("t1");
      cfa(16'h1234, 16'h5678, lat); check("t2_lat_a", 32'(lat), 3);
      cfa(16'h9ABC, 16'hDEF0, lat); check("t2_lat_b", 32'(lat), 3); status("t2_ptr6");
      cfa(16'h0F0F, 16'hF0F0, lat); status("t2_ptr8");
      spec(8'd2, 16'hAAAA, 16'h5555, lat); check("t2_spec_lat", 32'(lat), 3); status("t2_spec");
      spec(8'd6, 16'h1357, 16'h2468, lat); check("top_spec_lat", 32'(lat), 3);
      spec(8'd3, 16'h1111, 16'h2222, lat); check("t3_odd_lat", 32'(lat), 2);
      spec(8'd8, 16'h3333, 16'h4444, lat); check("t3_range_lat", 32'(lat), 2); status("t3");
      cfa(16'hCCCC, 16'hDDDD, lat); check("t5_drop_lat", 32'(lat), 2); status("t5_drop");
      @(posedge mclk); #1 clear_req = 1'b1;
      @(posedge mclk); #1 clear_req = 1'b0;
      ptr_m = '0; drop_m = '0;
      status("t5_clear");
      cfa(16'h1111, 16'h2222, lat);
      push_pair(8'd0, 16'hBEEF, 16'hCAFE); ack_q.push_back(4'b0010);
      push_pair(8'd2, 16'h7777, 16'h8888); ack_q.push_back(4'b1000);
      ptr_m = ptr_m + 9'd2;
      ts = 0; tc = 0;
      @(posedge mclk); #1;
      spec_req = 1'b1; spec_addr = 8'd0; spec_upper = 16'hBEEF; spec_lower = 16'hCAFE;
      cfa_req = 1'b1; cfa_src = 16'h7777; cfa_dest = 16'h8888;
      for (int i = 0; i < 20 && (ts == 0 || tc == 0); i++) begin
         @(negedge mclk);
         if (spec_ack) begin ts = cyc; spec_req = 1'b0; end
         if (cfa_ack) begin tc = cyc; cfa_req = 1'b0; end
      end
      spec_req = 1'b0; cfa_req = 1'b0;
      check("t4_gap", 32'(tc - ts), 3);
      status("t4");
      @(posedge mclk); #1;
      cfa_req = 1'b1; cfa_src = 16'h3333; cfa_dest = 16'h4444;
      wr_q.push_back({8'h0, ptr_m[AW-1:0], 16'h3333});
      repeat (2) @(posedge mclk);
      #2 puc_rst_n = 1'b0; cfa_req = 1'b0;
      #1;
      check("t6_we", 32'(mem_we), 0);
      check("t6_ack", 32'(cfa_ack), 0);
      check("t6_wdata", 32'(mem_wdata), 0);
      check("t6_ptr", 32'(log_ptr), 0);
      ptr_m = '0; drop_m = '0;
      @(posedge mclk); #1 puc_rst_n = 1'b1;
      cfa(16'h5555, 16'h6666, lat); check("t6_lat", 32'(lat), 3); status("t6");
      @(posedge mclk); #1;
      check("wr_q_empty", 32'(wr_q.size()), 0);
      check("ack_q_empty", 32'(ack_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
